// File: rtl/factorial_engine_if.sv
// factorial_engine_if
//   Request/result bundle for factorial_engine.
//   n         : signed 28-bit operand, sampled on the accepting edge
//   valid_in  : single-cycle request strobe
//   valid_out : single-cycle result strobe
//   ovrflow   : error flag accompanying the result
//   d_out     : signed 28-bit result, held until the next valid_out
//   master drives the request side, slave (the engine) drives the result side.
interface factorial_engine_if;
  logic signed [27:0] n;
  logic               valid_in;
  logic               valid_out;
  logic               ovrflow;
  logic signed [27:0] d_out;

  modport master (
    output n,
    output valid_in,
    input  valid_out,
    input  ovrflow,
    input  d_out
  );

  modport slave (
    input  n,
    input  valid_in,
    output valid_out,
    output ovrflow,
    output d_out
  );
endinterface

// File: rtl/factorial_engine.sv
// factorial_engine
//   Sequential integer factorial, one multiply per clock.
//   Accepts a signed 28-bit operand on bus.valid_in while idle and returns n!
//   with a one-cycle bus.valid_out pulse. Operands outside 0..11 give
//   bus.ovrflow=1 with bus.d_out=0.
//   Optional build macro FACTORIAL_SAT_EN: operands > 11 return 28'sh7FFFFFF
//   instead of 0 (negative operands still return 0).
// Ports
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : factorial_engine_if.slave (n, valid_in in; valid_out, ovrflow, d_out out)
module factorial_engine (
  input  logic               clk,
  input  logic               rst,
  factorial_engine_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [27:0]        acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               vout_q, vout_d;
  logic               ovf_q, ovf_d;
  logic signed [27:0] dout_q, dout_d;
`ifdef FACTORIAL_SAT_EN
  // Distinguishes a too-large operand (saturate) from a negative one (zero).
  logic               sat_q, sat_d;
`endif

  logic               legal;
  logic [27:0]        prod;

  // Non-negative and magnitude no larger than 11.
  assign legal = ~bus.n[27] && (bus.n[26:0] <= 27'd11);
  assign prod  = acc_q * {24'd0, cnt_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vout_d  = 1'b0;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
`ifdef FACTORIAL_SAT_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          acc_d   = 28'd1;
          state_d = CALC;
          if (legal) begin
            cnt_d = bus.n[3:0];
            err_d = 1'b0;
          end else begin
            // cnt=1 makes the error path finish on the very next edge.
            cnt_d = 4'd1;
            err_d = 1'b1;
          end
`ifdef FACTORIAL_SAT_EN
          sat_d = ~legal & ~bus.n[27];
`endif
        end
      end
      CALC: begin
        if (cnt_q > 4'd1) begin
          acc_d = prod;
          cnt_d = cnt_q - 4'd1;
        end else begin
          vout_d  = 1'b1;
          ovf_d   = err_q;
          state_d = IDLE;
          if (err_q) begin
`ifdef FACTORIAL_SAT_EN
            dout_d = sat_q ? 28'sh7FFFFFF : '0;
`else
            dout_d = '0;
`endif
          end else begin
            dout_d = signed'(acc_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= 28'd1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
`ifdef FACTORIAL_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vout_q  <= vout_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
`ifdef FACTORIAL_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.valid_out = vout_q;
  assign bus.ovrflow   = ovf_q;
  assign bus.d_out     = dout_q;

endmodule

// File: tb/tb_factorial_engine.sv
module tb_factorial_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  factorial_engine_if bus ();

  factorial_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int d;
    bit ov;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_d = 0;
  bit   last_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_d(input int v);
    int f;
    if (v < 0) return 0;
    if (v > 11) begin
`ifdef FACTORIAL_SAT_EN
      return 134217727;
`else
      return 0;
`endif
    end
    f = 1;
    for (int i = 2; i <= v; i++) f = f * i;
    return f;
  endfunction

  // Monitor: pops the scoreboard on every result strobe and checks that the
  // outputs hold between strobes.
  always @(negedge clk) begin
    if (!rst) begin
      last_d  = 0;
      last_ov = 1'b0;
    end else if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d_out", bus.d_out, e.d);
        chk("ovrflow", {31'd0, bus.ovrflow}, {31'd0, e.ov});
        chk("latency_cycle", cyc, e.cyc);
        last_d  = e.d;
        last_ov = e.ov;
      end
    end else begin
      chk("d_out_hold", bus.d_out, last_d);
      chk("ovrflow_hold", {31'd0, bus.ovrflow}, {31'd0, last_ov});
    end
  end

  // Called right after a negedge; accepting edge is the next posedge.
  task automatic send(input int v);
    exp_t e;
    int lat;
    lat = (v >= 0 && v <= 11) ? ((v > 1) ? v : 1) : 1;
    e.d   = model_d(v);
    e.ov  = !(v >= 0 && v <= 11);
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    bus.n        = 28'(v);
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_vout(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    bus.n        = '0;
    bus.valid_in = 1'b0;

    // Reset
    @(negedge clk);
    chk("rst_valid_out", {31'd0, bus.valid_out}, 0);
    chk("rst_ovrflow", {31'd0, bus.ovrflow}, 0);
    chk("rst_d_out", bus.d_out, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid_out", {31'd0, bus.valid_out}, 0);
    chk("post_rst_d_out", bus.d_out, 0);

    // n=5 and pulse width
    send(5);
    wait_vout("n5");
    @(negedge clk);
    chk("pulse_width", {31'd0, bus.valid_out}, 0);

    // Error operands
    send(15);
    wait_vout("n15");
    @(negedge clk);
    send(-1);
    wait_vout("nneg1");
    @(negedge clk);

    // Back-to-back: each request in the predecessor's valid_out cycle
    send(6);
    wait_vout("n6");
    send(0);
    wait_vout("n0");
    send(11);
    wait_vout("n11");
    send(1);
    wait_vout("n1");
    @(negedge clk);

    // Re-pulse while busy must be dropped
    send(7);
    repeat (2) @(negedge clk);
    bus.n        = 28'sd3;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    wait_vout("n7");
    repeat (12) @(negedge clk);

    // Reset mid-computation: no result, outputs cleared
    bus.n        = 28'sd9;
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid_out", {31'd0, bus.valid_out}, 0);
    chk("midrst_d_out", bus.d_out, 0);
    chk("midrst_ovrflow", {31'd0, bus.ovrflow}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);

    // Recovery after abort
    send(3);
    wait_vout("n3");
    @(negedge clk);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
